// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BHT+BTB fetch predictor with EX-driven training and redirect
// Combinational 0-cycle prediction, registered mispredict/redirect, saturating statistics.
module branch_predictor #(
  parameter int          XLEN       = 32,
  parameter int          INDEX_BITS = 6,
  parameter int          TAG_BITS   = 8,
  parameter logic [31:0] STAT_INIT  = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);
  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [1:0]          ctr_q [ENTRIES];
  logic [XLEN-1:0]     tgt_q [ENTRIES];

  logic            mispredict_q, mispredict_d;
  logic [XLEN-1:0] redirect_q, redirect_d;
  logic [31:0]     stat_br_q, stat_br_d;
  logic [31:0]     stat_mp_q, stat_mp_d;

  logic [INDEX_BITS-1:0] p_idx, u_idx;
  logic [TAG_BITS-1:0]   p_tag, u_tag;
  logic                  p_hit, u_hit;
  logic [1:0]            ctr_d;
  logic [XLEN-1:0]       tgt_d;

  assign p_idx = pred_pc[INDEX_BITS+1:2];
  assign p_tag = pred_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign u_idx = upd_pc[INDEX_BITS+1:2];
  assign u_tag = upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

  // Prediction reads pre-update table contents; no bypass from a same-cycle update.
  assign p_hit       = valid_q[p_idx] && (tag_q[p_idx] == p_tag);
  assign pred_taken  = p_hit && ctr_q[p_idx][1];
  assign pred_target = pred_taken ? tgt_q[p_idx] : pred_pc + XLEN'(4);

  always_comb begin
    u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    ctr_d = ctr_q[u_idx];
    tgt_d = tgt_q[u_idx];
    if (u_hit) begin
      if (upd_taken) begin
        if (ctr_d != 2'b11) ctr_d = ctr_d + 2'd1;
        tgt_d = upd_target;
      end else if (ctr_d != 2'b00) begin
        ctr_d = ctr_d - 2'd1;
      end
    end else begin
      ctr_d = upd_taken ? 2'b10 : 2'b01;
      tgt_d = upd_target;
    end
    mispredict_d = upd_valid &&
                   ((upd_taken != upd_pred_taken) ||
                    (upd_taken && (upd_pred_target != upd_target)));
    redirect_d   = upd_taken ? upd_target : upd_pc + XLEN'(4);
    stat_br_d    = (stat_br_q == 32'hFFFF_FFFF) ? stat_br_q : stat_br_q + 32'd1;
    stat_mp_d    = (stat_mp_q == 32'hFFFF_FFFF) ? stat_mp_q : stat_mp_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        ctr_q[i] <= 2'b01;
        tgt_q[i] <= '0;
      end
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      stat_br_q    <= STAT_INIT;
      stat_mp_q    <= STAT_INIT;
    end else begin
      mispredict_q <= mispredict_d;
      if (upd_valid) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        ctr_q[u_idx]   <= ctr_d;
        tgt_q[u_idx]   <= tgt_d;
        stat_br_q      <= stat_br_d;
      end
      if (mispredict_d) begin
        redirect_q <= redirect_d;
        stat_mp_q  <= stat_mp_d;
      end
    end
  end

  assign mispredict       = mispredict_q;
  assign redirect_pc      = redirect_q;
  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor with behavioural table model
// A second instance starts its statistics near all-ones so saturation is reached quickly.
module tb_branch_predictor;
  localparam logic [31:0] SAT_INIT = 32'hFFFF_FFFD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pred_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = '0;

  logic        pred_taken, pred_taken2, mispredict, mispredict2;
  logic [31:0] pred_target, pred_target2, redirect_pc, redirect_pc2;
  logic [31:0] stat_branches, stat_mispredicts, stat_branches2, stat_mispredicts2;

  int n_checks = 0;
  int n_pass   = 0;

  branch_predictor dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  branch_predictor #(.STAT_INIT(SAT_INIT)) dut_sat (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken2), .pred_target(pred_target2),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict2), .redirect_pc(redirect_pc2),
    .stat_branches(stat_branches2), .stat_mispredicts(stat_mispredicts2)
  );

  always #5 clk = ~clk;

  // Reference model: one record per table slot, counters as plain integers 0..3.
  bit          m_valid [64];
  int          m_tag   [64];
  int          m_ctr   [64];
  logic [31:0] m_tgt   [64];
  longint      m_nbr, m_nmp;
  logic [31:0] m_redirect;

  typedef struct { logic [31:0] pc; bit taken; logic [31:0] target; } pred_exp_t;
  typedef struct { bit mp; logic [31:0] redir; logic [31:0] br1, mp1, br2, mp2; } resp_exp_t;
  typedef struct { bit uv; logic [31:0] pc; bit taken; logic [31:0] tgt; bit ptaken; logic [31:0] ptgt; } upd_t;

  pred_exp_t pred_q[$];
  resp_exp_t resp_q[$];
  upd_t      prev;
  bit        have_prev = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [31:0] sat(input logic [31:0] init, input longint n);
    longint s;
    s = longint'(init) + n;
    return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic int idx_of(input logic [31:0] pc); return int'((pc >> 2) % 64); endfunction
  function automatic int tag_of(input logic [31:0] pc); return int'((pc >> 8) % 256); endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = '0;
    end
    m_nbr = 0; m_nmp = 0; m_redirect = '0;
  endtask

  task automatic model_predict(input logic [31:0] pc, output bit taken, output logic [31:0] target);
    int i;
    i = idx_of(pc);
    taken  = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
    target = taken ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic model_update(input upd_t u, output bit mp);
    int i;
    mp = 0;
    if (!u.uv) return;
    i = idx_of(u.pc);
    if (m_valid[i] && m_tag[i] == tag_of(u.pc)) begin
      if (u.taken) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = u.tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else begin
      m_valid[i] = 1; m_tag[i] = tag_of(u.pc);
      m_ctr[i] = u.taken ? 2 : 1; m_tgt[i] = u.tgt;
    end
    m_nbr++;
    mp = (u.taken != u.ptaken) || (u.taken && u.ptgt != u.tgt);
    if (mp) begin
      m_nmp++;
      m_redirect = u.taken ? u.tgt : u.pc + 32'd4;
    end
  endtask

  task automatic step(input logic [31:0] ppc, input bit uv, input logic [31:0] upc, input bit ut,
                      input logic [31:0] utgt, input bit upt, input logic [31:0] uptgt);
    bit mp;
    pred_exp_t pe;
    resp_exp_t re;
    @(posedge clk); #1;
    if (have_prev) begin
      model_update(prev, mp);
      re.mp = mp; re.redir = m_redirect;
      re.br1 = sat(32'h0, m_nbr); re.mp1 = sat(32'h0, m_nmp);
      re.br2 = sat(SAT_INIT, m_nbr); re.mp2 = sat(SAT_INIT, m_nmp);
      resp_q.push_back(re);
    end
    pred_pc = ppc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt;
    pe.pc = ppc;
    model_predict(ppc, pe.taken, pe.target);
    pred_q.push_back(pe);
    prev = '{uv, upc, ut, utgt, upt, uptgt};
    have_prev = 1;
  endtask

  task automatic idle(input logic [31:0] ppc);
    step(ppc, 0, '0, 0, '0, 0, '0);
  endtask

  always @(negedge clk) begin
    pred_exp_t pe;
    resp_exp_t re;
    if (pred_q.size() > 0) begin
      pe = pred_q.pop_front();
      chk($sformatf("pred_taken@%h", pe.pc), {31'b0, pred_taken}, {31'b0, pe.taken});
      chk($sformatf("pred_target@%h", pe.pc), pred_target, pe.target);
    end
    if (resp_q.size() > 0) begin
      re = resp_q.pop_front();
      chk("mispredict", {31'b0, mispredict}, {31'b0, re.mp});
      chk("redirect_pc", redirect_pc, re.redir);
      chk("stat_branches", stat_branches, re.br1);
      chk("stat_mispredicts", stat_mispredicts, re.mp1);
      chk("stat_branches_sat", stat_branches2, re.br2);
      chk("stat_mispredicts_sat", stat_mispredicts2, re.mp2);
    end
  end

  function automatic logic [31:0] rnd_pc();
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
  endfunction

  task automatic check_reset_state(input logic [31:0] probe_pc);
    pred_pc = probe_pc; #1;
    chk("rst pred_taken", {31'b0, pred_taken}, 32'd0);
    chk("rst pred_target", pred_target, probe_pc + 32'd4);
    chk("rst mispredict", {31'b0, mispredict}, 32'd0);
    chk("rst redirect_pc", redirect_pc, 32'd0);
    chk("rst stat_branches", stat_branches, 32'd0);
    chk("rst stat_mispredicts", stat_mispredicts, 32'd0);
    chk("rst stat_branches_sat", stat_branches2, SAT_INIT);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ut, upt;
    logic [31:0] upc, utgt, uptgt;

    model_reset();
    #12;
    check_reset_state(32'h0000_1234);
    @(negedge clk); rst = 1'b0;

    // Train 0x100 taken while it was predicted not-taken.
    step(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104);
    idle(32'h100);
    // Saturate high, then two not-taken steps drop it to weakly not-taken.
    for (int i = 0; i < 4; i++) step(32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80);
    step(32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80);
    idle(32'h100);
    step(32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80);
    idle(32'h100);
    // Alias replacement on the same index.
    step(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104);
    step(32'h100, 1, 32'h100 + 32'h100, 0, 32'h40, 0, 32'h204);
    idle(32'h100);
    // Same-cycle predict and update on one index.
    step(32'h200, 1, 32'h200, 1, 32'h300, 0, 32'h204);
    idle(32'h200);
    idle(32'hFFFF_FFFC);
    // Correct taken direction with a wrong target is still a mispredict.
    step(32'h200, 1, 32'h200, 1, 32'h340, 1, 32'h300);
    idle(32'h200);

    for (int n = 0; n < 300; n++) begin
      upc  = rnd_pc();
      ut   = 1'($urandom_range(0, 1));
      utgt = 32'h1000 + (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 3) != 0) model_predict(upc, upt, uptgt);
      else begin
        upt = 1'($urandom_range(0, 1));
        uptgt = 32'h1000 + (32'($urandom_range(0, 3)) << 2);
      end
      step(($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : rnd_pc(),
           $urandom_range(0, 3) != 0, upc, ut, utgt, upt, uptgt);
    end

    // Leave a mispredict registered, then reset between clock edges.
    step(32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80);
    step(32'h100, 1, 32'h100, 1, 32'h88, 0, 32'h104);
    @(posedge clk); #3;
    rst = 1'b1;
    upd_valid = 1'b0;
    pred_q.delete(); resp_q.delete();
    have_prev = 0;
    model_reset();
    check_reset_state(32'h100);
    @(negedge clk); @(negedge clk); rst = 1'b0;

    step(32'h100, 1, 32'h100, 0, 32'h80, 0, 32'h104);
    step(32'h100, 1, 32'h180, 1, 32'h2000, 0, 32'h184);
    idle(32'h180);
    idle(32'h100);
    @(negedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
